avst_multichannel_predelay: RTL

Parametrised, multi-channel Avalon-ST predelay line for the reverb datapath. It sits between the audio controller's channel source and the reverb core. Each channel is delayed by a runtime-programmable number of samples (predelay PIO value) using one shared ring-buffer RAM. It supports N interleaved channels, bypass, and zero-fill of not-yet-written history.

---
 rtl/avst_multichannel_predelay.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/avst_multichannel_predelay.sv
// Multi-channel Avalon-ST predelay line: each interleaved channel is delayed by a
// programmable number of samples through one shared ring-buffer RAM.
module avst_multichannel_predelay #(
    parameter int DATA_W     = 24,
    parameter int N_CH       = 2,
    parameter int CH_W       = 1,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     sink_data,
    input  logic [CH_W-1:0]       sink_channel,
    input  logic                  sink_valid,
    output logic                  sink_ready,
    output logic [DATA_W-1:0]     source_data,
    output logic [CH_W-1:0]       source_channel,
    output logic                  source_valid,
    input  logic                  source_ready,
    input  logic [DEPTH_LOG2-1:0] delay_value,
    input  logic                  delay_update,
    input  logic                  bypass,
    output logic                  chan_err
);

    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int MEM_WORDS = N_CH * DEPTH;
    localparam int MEM_AW    = $clog2(MEM_WORDS);
    localparam int CI_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [DEPTH_LOG2:0] FILL_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    function automatic logic [DEPTH_LOG2:0] fill_inc(input logic [DEPTH_LOG2:0] f);
        return (f == FILL_MAX) ? f : f + 1'b1;
    endfunction

    // Bypass and zero delay take the live sample; unwritten history reads as silence.
    function automatic logic signed [DATA_W-1:0] select_out(
        input logic signed [DATA_W-1:0] smp,
        input logic signed [DATA_W-1:0] rd,
        input logic                     byp,
        input logic [DEPTH_LOG2-1:0]    d,
        input logic [DEPTH_LOG2:0]      fsnap
    );
        if (byp || d == '0) return smp;
        if (fsnap < {1'b0, d}) return '0;
        return rd;
    endfunction

    logic [1:0]                  state, next_state;
    logic                        sink_ready_q;
    logic                        source_valid_p1;
    logic                        chan_err_q;

    logic signed [DATA_W-1:0]    mem [MEM_WORDS];
    logic signed [DATA_W-1:0]    sample_p0;
    logic signed [DATA_W-1:0]    rd_data_p0;
    logic signed [DATA_W-1:0]    source_data_p1;
    logic [CH_W-1:0]             ch_p0;
    logic [CH_W-1:0]             source_channel_p1;
    logic                        byp_p0;
    logic [DEPTH_LOG2-1:0]       dly_p0;
    logic [DEPTH_LOG2:0]         fill_snap_p0;

    logic [DEPTH_LOG2-1:0]       wr_ptr [N_CH];
    logic [DEPTH_LOG2:0]         fill   [N_CH];
    logic [DEPTH_LOG2-1:0]       active_delay;
    logic [DEPTH_LOG2-1:0]       pending_delay;
    logic                        pending_flag;

    logic                        ch_ok;
    logic                        accept;
    logic                        take;
    logic                        in_read;
    logic                        in_idle;
    logic [CH_W-1:0]             ch_safe;
    logic [CI_W-1:0]             in_idx;
    logic [CI_W-1:0]             p0_idx;
    logic [DEPTH_LOG2-1:0]       rd_ptr;
    logic [MEM_AW-1:0]           rd_addr;
    logic [MEM_AW-1:0]           wr_addr;

    assign in_idle = (state == ST_IDLE);
    assign in_read = (state == ST_READ);
    assign ch_ok   = (32'(sink_channel) < N_CH);
    assign accept  = in_idle && sink_valid;
    assign take    = accept && ch_ok;
    assign ch_safe = ch_ok ? sink_channel : '0;
    assign in_idx  = CI_W'(ch_safe);
    assign p0_idx  = CI_W'(ch_p0);
    assign rd_ptr  = wr_ptr[in_idx] - active_delay;
    assign rd_addr = MEM_AW'({ch_safe, rd_ptr});
    assign wr_addr = MEM_AW'({ch_p0, wr_ptr[p0_idx]});

    assign sink_ready     = sink_ready_q & ~reset;
    assign source_valid   = source_valid_p1;
    assign source_data    = source_data_p1;
    assign source_channel = source_channel_p1;
    assign chan_err       = chan_err_q;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (take) next_state = ST_READ;
            ST_READ: next_state = ST_OUT;
            ST_OUT:  if (source_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Stage p0: capture accepted sample and its context; RAM read is issued alongside.
    always_ff @(posedge clk) begin
        if (take) begin
            sample_p0    <= sink_data;
            ch_p0        <= sink_channel;
            byp_p0       <= bypass;
            dly_p0       <= active_delay;
            fill_snap_p0 <= fill[in_idx];
        end
    end

    // Read happens in IDLE and write in READ, so the two ports never collide.
    always_ff @(posedge clk) begin
        if (in_read && !reset) mem[wr_addr] <= sample_p0;
        if (take) rd_data_p0 <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            sink_ready_q    <= 1'b1;
            source_valid_p1 <= 1'b0;
            chan_err_q      <= 1'b0;
            active_delay    <= '0;
            pending_delay   <= '0;
            pending_flag    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr[i] <= '0;
                fill[i]   <= '0;
            end
        end else begin
            state           <= next_state;
            sink_ready_q    <= (next_state == ST_IDLE);
            source_valid_p1 <= (next_state == ST_OUT);
            if (accept && !ch_ok) chan_err_q <= 1'b1;

            // A fresh strobe re-arms the flag even while an older value is being applied.
            if (delay_update) begin
                pending_delay <= delay_value;
                pending_flag  <= 1'b1;
            end else if (in_idle && pending_flag) begin
                pending_flag  <= 1'b0;
            end
            if (in_idle && pending_flag) active_delay <= pending_delay;

            if (in_read) begin
                wr_ptr[p0_idx] <= wr_ptr[p0_idx] + 1'b1;
                fill[p0_idx]   <= fill_inc(fill[p0_idx]);
            end
        end
    end

    // Stage p1: output register, loaded at the READ->OUT edge and held through backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            source_data_p1    <= '0;
            source_channel_p1 <= '0;
        end else if (in_read) begin
            source_data_p1    <= select_out(sample_p0, rd_data_p0, byp_p0, dly_p0, fill_snap_p0);
            source_channel_p1 <= ch_p0;
        end
    end

endmodule
